// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 16-bit core: opcode field width and values as
//   decoded by the control unit, default bus widths, and the instruction-fetch
//   state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int OPC_W       = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 16;

  localparam logic [OPC_W-1:0] OP_LOAD  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_STORE = 4'b0010;
  localparam logic [OPC_W-1:0] OP_STRI  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_BRA   = 4'b1000;
  localparam logic [OPC_W-1:0] OP_COMP  = 4'b1010;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'b00,
    IF_FETCH = 2'b01,
    IF_FLUSH = 2'b10,
    IF_HOLD  = 2'b11
  } if_state_e;

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
//   Program-counter register. Load of a branch target wins over increment,
//   increment wins over hold. Increment wraps modulo 2^ADDR_W.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset (pc -> RESET_PC)
//     load        take target this cycle
//     inc         advance by one this cycle (ignored when load=1)
//     target      value loaded on load
//     pc          current program counter
// -----------------------------------------------------------------------------
module pc_reg
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= RESET_PC;
    else if (load) pc <= target;
    else if (inc)  pc <= pc + 1'b1;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage: owns the PC, fetches one word at a time over a req/ack memory
//   port and presents it to decode with a valid/stall handshake. A branch from
//   execute redirects the PC; a word whose request was in flight at the time of
//   the branch is squashed rather than shown.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     imem_req/imem_addr         fetch request and word address (registered)
//     imem_ack/imem_rdata        read data strobe and instruction word
//     branch_taken/branch_target redirect pulse and new PC
//     stall                      decode cannot accept the presented word
//     if_valid/if_instr          presented word and its qualifier
//     if_opcode/if_pc            opcode field and source address of if_instr
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [OPC_W-1:0]   if_opcode,
  output logic [ADDR_W-1:0]  if_pc
);

  if_state_e         state;
  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic              pc_inc;

  // A branch retargets the PC in every state; the PC only advances when a
  // non-squashed word is captured.
  assign pc_load = branch_taken;
  assign pc_inc  = (state == IF_FETCH) && imem_ack && !branch_taken;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (branch_target),
    .pc     (pc)
  );

  // NOTE: the reset branch must assign every register this block drives;
  // a register left out would hold its value through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IF_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_opcode <= '0;
      if_pc     <= '0;
    end else begin
      case (state)
        IF_IDLE: begin
          // pc_reg loads the target on this same edge, so forward it here.
          imem_req  <= 1'b1;
          imem_addr <= branch_taken ? branch_target : pc;
          state     <= IF_FETCH;
        end

        IF_FETCH: begin
          if (branch_taken) begin
            if (imem_ack) begin
              imem_req <= 1'b0;
              state    <= IF_IDLE;
            end else begin
              // Request stays up with its old address until its ack drains.
              state <= IF_FLUSH;
            end
          end else if (imem_ack) begin
            if_instr  <= imem_rdata;
            if_opcode <= imem_rdata[INSTR_W-1 -: OPC_W];
            if_pc     <= pc;
            if_valid  <= 1'b1;
            imem_req  <= 1'b0;
            state     <= IF_HOLD;
          end
        end

        IF_FLUSH: begin
          if (imem_ack) begin
            if (branch_taken) begin
              imem_req <= 1'b0;
              state    <= IF_IDLE;
            end else begin
              // Squashed data dropped; req stays high and now names the target.
              imem_addr <= pc;
              state     <= IF_FETCH;
            end
          end
        end

        IF_HOLD: begin
          if (branch_taken) begin
            if_valid <= 1'b0;
            imem_req <= 1'b0;
            state    <= IF_IDLE;
          end else if (!stall) begin
            if_valid  <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= IF_FETCH;
          end
        end

        default: state <= IF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit: a table of fetch vectors, hand
//   sequences for branch/stall/reset corners, a second instance with
//   RESET_PC=8'hFF, and a randomized run against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [3:0]  if_opcode;
  logic [7:0]  if_pc;

  logic        f_rst_n;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        f_branch;
  logic [7:0]  f_target;
  logic        f_stall;
  logic        f_valid;
  logic [15:0] f_instr;
  logic [3:0]  f_opcode;
  logic [7:0]  f_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode), .if_pc(if_pc)
  );

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFF)) dut_ff (
    .clk(clk), .rst_n(f_rst_n),
    .imem_req(f_req), .imem_addr(f_addr),
    .imem_ack(f_ack), .imem_rdata(f_rdata),
    .branch_taken(f_branch), .branch_target(f_target),
    .stall(f_stall),
    .if_valid(f_valid), .if_instr(f_instr), .if_opcode(f_opcode), .if_pc(f_pc)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check({name, " req rises"}, 32'(imem_req), 32'd1);
  endtask

  // Wait for a request, check its address, ack after lat cycles with word.
  task automatic serve(input logic [7:0] exp_addr, input int lat,
                       input logic [15:0] word, input string name);
    wait_req(name);
    check({name, " req addr"}, 32'(imem_addr), 32'(exp_addr));
    repeat (lat) begin
      tick();
      check({name, " req held"}, 32'(imem_req), 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " req"},    32'(imem_req),  32'd0);
    check({name, " addr"},   32'(imem_addr), 32'd0);
    check({name, " valid"},  32'(if_valid),  32'd0);
    check({name, " instr"},  32'(if_instr),  32'd0);
    check({name, " opcode"}, 32'(if_opcode), 32'd0);
    check({name, " pc"},     32'(if_pc),     32'd0);
  endtask

  typedef struct {
    logic [15:0] word;
    int          lat;
    int          stall_cyc;
    logic [7:0]  exp_pc;
    logic [3:0]  exp_opc;
  } vec_t;

  vec_t vecs [6];

  // Random-phase model state.
  logic [15:0] mem [256];
  logic [7:0]  exp_next;
  logic        prev_req, prev_ack, prev_valid, prev_stall, prev_branch;
  logic [7:0]  prev_addr, prev_pc, prev_target;
  logic [15:0] prev_instr;
  int          age, lat, n_pres;

  initial begin
    logic [7:0] nxt;

    vecs[0] = '{16'h0A01, 1, 0, 8'h00, OP_LOAD};
    vecs[1] = '{16'h2B02, 1, 0, 8'h01, OP_STORE};
    vecs[2] = '{16'h4C03, 1, 0, 8'h02, OP_STRI};
    vecs[3] = '{16'hA123, 1, 5, 8'h03, OP_COMP};
    vecs[4] = '{16'h8F55, 2, 1, 8'h04, OP_BRA};
    vecs[5] = '{16'hFFFF, 3, 0, 8'h05, 4'hF};

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    branch_taken = 1'b0; branch_target = '0; stall = 1'b0;
    f_rst_n = 1'b0; f_ack = 1'b0; f_rdata = '0;
    f_branch = 1'b0; f_target = '0; f_stall = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    check("reset ff addr", 32'(f_addr), 32'hFF);
    check("reset ff req",  32'(f_req),  32'd0);

    // RESET_PC = 8'hFF: first fetch at FF, next at 00.
    f_rst_n = 1'b1;
    begin
      int n = 0;
      while (!f_req && n < 10) begin
        tick();
        n++;
      end
    end
    check("ff first req",  32'(f_req),  32'd1);
    check("ff first addr", 32'(f_addr), 32'hFF);
    tick();
    f_ack = 1'b1; f_rdata = 16'h8001;
    tick();
    f_ack = 1'b0;
    check("ff valid",  32'(f_valid),  32'd1);
    check("ff pc",     32'(f_pc),     32'hFF);
    check("ff opcode", 32'(f_opcode), 32'(OP_BRA));
    tick();
    check("ff consumed",  32'(f_valid), 32'd0);
    check("ff wrap req",  32'(f_req),   32'd1);
    check("ff wrap addr", 32'(f_addr),  32'h00);

    // Table-driven sequential fetches with varying latency and stall.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      serve(vecs[i].exp_pc, vecs[i].lat, vecs[i].word, "vec");
      check("vec valid",  32'(if_valid),  32'd1);
      check("vec pc",     32'(if_pc),     32'(vecs[i].exp_pc));
      check("vec instr",  32'(if_instr),  32'(vecs[i].word));
      check("vec opcode", 32'(if_opcode), 32'(vecs[i].exp_opc));
      stall = (vecs[i].stall_cyc > 0);
      for (int j = 0; j < vecs[i].stall_cyc; j++) begin
        tick();
        check("stall valid held", 32'(if_valid), 32'd1);
        check("stall instr held", 32'(if_instr), 32'(vecs[i].word));
        check("stall pc held",    32'(if_pc),    32'(vecs[i].exp_pc));
        check("stall no req",     32'(imem_req), 32'd0);
      end
      stall = 1'b0;
      tick();
      nxt = vecs[i].exp_pc + 8'd1;
      check("consume valid", 32'(if_valid),  32'd0);
      check("consume req",   32'(imem_req),  32'd1);
      check("consume addr",  32'(imem_addr), 32'(nxt));
    end

    // Branch in FETCH, squashed ack three cycles later.
    branch_taken = 1'b1; branch_target = 8'h40;
    tick();
    branch_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("flush req held",  32'(imem_req),  32'd1);
      check("flush addr held", 32'(imem_addr), 32'h06);
      check("flush no valid",  32'(if_valid),  32'd0);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    imem_ack = 1'b0;
    check("squash no valid", 32'(if_valid),  32'd0);
    check("squash reissue",  32'(imem_req),  32'd1);
    check("squash addr",     32'(imem_addr), 32'h40);
    serve(8'h40, 1, 16'h1040, "target");
    check("target valid", 32'(if_valid), 32'd1);
    check("target pc",    32'(if_pc),    32'h40);
    tick();

    // Branch in the same cycle as ack.
    tick();
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    branch_taken = 1'b1; branch_target = 8'h10;
    tick();
    imem_ack = 1'b0; branch_taken = 1'b0;
    check("br+ack no valid", 32'(if_valid), 32'd0);
    check("br+ack idle req", 32'(imem_req), 32'd0);
    tick();
    check("br+ack req",  32'(imem_req),  32'd1);
    check("br+ack addr", 32'(imem_addr), 32'h10);
    serve(8'h10, 1, 16'h5010, "br+ack");
    check("br+ack fetched pc", 32'(if_pc), 32'h10);

    // Branch in HOLD while stalled.
    stall = 1'b1;
    tick();
    check("hold stalled valid", 32'(if_valid), 32'd1);
    branch_taken = 1'b1; branch_target = 8'h20;
    tick();
    branch_taken = 1'b0;
    check("hold branch drops valid", 32'(if_valid), 32'd0);
    check("hold branch req low",     32'(imem_req), 32'd0);
    stall = 1'b0;
    tick();
    check("hold branch req",  32'(imem_req),  32'd1);
    check("hold branch addr", 32'(imem_addr), 32'h20);

    // Reset asserted during FLUSH.
    tick();
    branch_taken = 1'b1; branch_target = 8'h30;
    tick();
    branch_taken = 1'b0;
    check("pre-reset flush req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    serve(8'h00, 2, 16'h7777, "post reset");
    check("post reset valid", 32'(if_valid), 32'd1);
    check("post reset pc",    32'(if_pc),    32'h00);
    check("post reset instr", 32'(if_instr), 32'h7777);

    // Randomized run against a transaction-level model: every shown word
    // must come from the expected address (sequential, or the latest branch
    // target), and handshake rules must hold cycle by cycle.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_next = 8'h00;
    prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0;
    prev_stall = 1'b0; prev_branch = 1'b0;
    prev_addr = '0; prev_pc = '0; prev_target = '0; prev_instr = '0;
    age = 0; lat = 1; n_pres = 0;
    imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      if (prev_branch) begin
        if (prev_valid) check("rnd branch drops valid", 32'(if_valid), 32'd0);
        exp_next = prev_target;
      end else if (prev_valid) begin
        if (prev_stall) begin
          check("rnd stall valid", 32'(if_valid), 32'd1);
          check("rnd stall instr", 32'(if_instr), 32'(prev_instr));
          check("rnd stall pc",    32'(if_pc),    32'(prev_pc));
        end else begin
          check("rnd consume", 32'(if_valid), 32'd0);
        end
      end
      if (if_valid && !prev_valid) begin
        n_pres++;
        check("rnd shown after ack", 32'(prev_ack && !prev_branch), 32'd1);
        check("rnd shown pc",        32'(if_pc),     32'(exp_next));
        check("rnd shown instr",     32'(if_instr),  32'(mem[if_pc]));
        check("rnd shown opcode",    32'(if_opcode), 32'(mem[if_pc] >> 12));
        exp_next = if_pc + 8'd1;
      end
      if (prev_req && !prev_ack) begin
        check("rnd req held",    32'(imem_req),  32'd1);
        check("rnd addr stable", 32'(imem_addr), 32'(prev_addr));
      end
      if (imem_req && (!prev_req || prev_ack)) begin
        check("rnd new req addr", 32'(imem_addr), 32'(exp_next));
        age = 0;
        lat = $urandom_range(1, 3);
      end else if (imem_req) begin
        age++;
      end

      imem_ack      = imem_req && (age >= lat);
      imem_rdata    = imem_ack ? mem[imem_addr] : 16'($urandom);
      stall         = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = 8'($urandom);

      prev_req    = imem_req;
      prev_ack    = imem_ack;
      prev_addr   = imem_addr;
      prev_valid  = if_valid;
      prev_instr  = if_instr;
      prev_pc     = if_pc;
      prev_stall  = stall;
      prev_branch = branch_taken;
      prev_target = branch_target;
    end
    check("rnd progress", 32'(n_pres > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
